sc_serialtx: RTL and testbench
==============================

Name: sc_serialtx

Overview:
- Parallel-to-serial frame transmitter on the read side of the general register.
- Captures the register output bus on an active-low send strobe from the control state machine.
- Shifts the word out LSB-first on one line, framed by a start bit (0) and a stop bit (1), each bit held for a programmable number of clocks.
- Reports busy status and an active-low one-cycle done strobe back to the controller.

Parameters:
- DATAWIDTH, 8, width of the parallel word transmitted per frame.
- BITPERIOD, 434, clock cycles per serial bit (50 MHz / 115200). Legal range is 1 or more.

Ports:
- SC_SERIALTX_CLOCK_50  input  1  system clock, rising edge.
- SC_SERIALTX_RESET_InLow  input  1  asynchronous reset, active-low.
- SC_SERIALTX_data_InBUS  input  DATAWIDTH  word to transmit; sampled only at frame acceptance.
- SC_SERIALTX_send_InLow  input  1  transmit request, active-low, level-sensitive.
- SC_SERIALTX_serial_Out  output  1  serial line; idles high.
- SC_SERIALTX_busy_Out  output  1  high while a frame is in progress.
- SC_SERIALTX_done_OutLow  output  1  low for exactly one cycle when a frame completes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (RESET_InLow=0): takes effect immediately, without waiting for a clock edge.
  - State=IDLE; serial_Out=1, busy_Out=0, done_OutLow=1.
  - Shift register and counters cleared.
- All outputs are registered. No combinational path from inputs to outputs.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - At a rising edge with send_InLow=0: load data_InBUS into the shift register; go to START; serial_Out<=0; busy_Out<=1; bit counter<=0.
  - Otherwise remain in IDLE with serial_Out=1.
- Bit timing:
  - A cycle counter runs from 0 to BITPERIOD-1, then wraps; each bit lasts exactly BITPERIOD cycles.
  - Counter width is clog2(BITPERIOD), minimum 1 bit.
  - BITPERIOD=1 gives one cycle per bit.
- START: at counter wrap, go to DATA; serial_Out<=shift[0].
- DATA:
  - At each counter wrap, shift right and increment the bit counter.
  - After DATAWIDTH bits, go to STOP with serial_Out<=1.
  - The bit counter is clog2(DATAWIDTH+1) wide.
- STOP: at counter wrap, go to IDLE; busy_Out<=0; done_OutLow<=0 for that single following cycle, then back to 1.
- Frame length: (DATAWIDTH+2)*BITPERIOD cycles. serial_Out goes low at the acceptance edge; busy_Out falls at the edge ending the stop bit.
- Back-to-back frames: send_InLow=0 during the cycle in which done_OutLow=0 (first IDLE cycle) is accepted at the next edge.
  - The gap is one idle-high cycle between stop bit and next start bit.
  - Holding send_InLow low therefore transmits continuously, with one idle cycle per frame.
- send_InLow while busy: ignored, not queued.
- data_InBUS changes while busy: no effect on the frame in progress.
- Reset during a frame: frame is aborted; serial_Out returns high immediately; no done pulse is issued for the aborted frame.
- After reset release: IDLE; the first frame requires a fresh send_InLow=0 sample.

Test Plan (DATAWIDTH=8, BITPERIOD=4):
1. Reset:
   - Assert RESET_InLow=0 mid-clock -> serial_Out=1, busy_Out=0, done_OutLow=1 before the next edge.
   - Release with send_InLow=1 for 20 cycles -> outputs unchanged.
2. Single frame:
   - data=0xA5, one-cycle send_InLow=0 -> serial_Out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
   - busy_Out=1 for those 40 cycles.
   - done_OutLow=0 for exactly cycle 41.
3. Data stability: same as scenario 2, but data_InBUS changes to 0xFF at cycle 10 -> serial bits still encode 0xA5.
4. Held request:
   - data=0x3C, send_InLow held low -> frames repeat with exactly one high idle cycle between the stop bit and the next start bit.
   - One done pulse per frame.
5. Ignored request: extra send_InLow=0 pulses at cycles 5 and 30 of a frame -> no change to the bit sequence and no second frame.
6. Abort: RESET_InLow=0 during data bit 3 -> serial_Out=1 and busy_Out=0 asynchronously; no done pulse; after release the line stays idle high until a new send.

Source files
------------

// File: rtl/sc_serialtx.sv
// sc_serialtx: parallel-to-serial frame transmitter.
// A frame is one start bit (0), DATAWIDTH data bits sent LSB first, and one
// stop bit (1). Each bit lasts BITPERIOD clocks. busy is high for the whole
// frame. done is low for the single cycle after the stop bit ends.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line high; accept a frame when send_InLow is sampled low
// START   | drive the start bit (0) for one bit period
// DATA    | shift the captured word out, LSB first, one bit per period
// STOP    | drive the stop bit (1); at its end pulse done and return
module sc_serialtx #(
    parameter int DATAWIDTH = 8,
    parameter int BITPERIOD = 434
) (
    input  logic                 SC_SERIALTX_CLOCK_50,
    input  logic                 SC_SERIALTX_RESET_InLow,
    input  logic [DATAWIDTH-1:0] SC_SERIALTX_data_InBUS,
    input  logic                 SC_SERIALTX_send_InLow,
    output logic                 SC_SERIALTX_serial_Out,
    output logic                 SC_SERIALTX_busy_Out,
    output logic                 SC_SERIALTX_done_OutLow
);

    localparam int CW = (BITPERIOD > 1) ? $clog2(BITPERIOD) : 1;
    localparam int BW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITPERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 wrap;
    logic [DATAWIDTH-1:0] shift_nx;

    assign wrap     = (cnt_q == CNT_LAST);
    assign shift_nx = shift_q >> 1;

    assign SC_SERIALTX_serial_Out  = serial_q;
    assign SC_SERIALTX_busy_Out    = busy_q;
    assign SC_SERIALTX_done_OutLow = done_q;

    // Next-state and registered-output logic; outputs are the next value of
    // the line so the line changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b1;

        if (state_q != ST_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                if (!SC_SERIALTX_send_InLow) begin
                    shift_d  = SC_SERIALTX_data_InBUS;
                    bitcnt_d = '0;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (wrap) begin
                    serial_d = shift_q[0];
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    shift_d  = shift_nx;
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == BIT_LAST) begin
                        serial_d = 1'b1;
                        state_d  = ST_STOP;
                    end else begin
                        serial_d = shift_nx[0];
                    end
                end
            end
            ST_STOP: begin
                if (wrap) begin
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge SC_SERIALTX_CLOCK_50 or negedge SC_SERIALTX_RESET_InLow) begin
        if (!SC_SERIALTX_RESET_InLow) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_sc_serialtx.sv
// Directed bench for sc_serialtx with DATAWIDTH=8, BITPERIOD=4.
module tb_sc_serialtx;

    localparam int DW = 8;
    localparam int BP = 4;
    localparam int FRAME = (DW + 2) * BP;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          send_n;
    logic          serial;
    logic          busy;
    logic          done_n;

    int n_checks;
    int n_errors;

    sc_serialtx #(
        .DATAWIDTH(DW),
        .BITPERIOD(BP)
    ) dut (
        .SC_SERIALTX_CLOCK_50   (clk),
        .SC_SERIALTX_RESET_InLow(rst_n),
        .SC_SERIALTX_data_InBUS (data),
        .SC_SERIALTX_send_InLow (send_n),
        .SC_SERIALTX_serial_Out (serial),
        .SC_SERIALTX_busy_Out   (busy),
        .SC_SERIALTX_done_OutLow(done_n)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for a given bit slot of a frame carrying d.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == DW + 1) return 1'b1;
        return d[slot-1];
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_serial"}, 32'(serial), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done_n), 32'd1);
    endtask

    // Single frame with optional data change at cycle 10 and optional
    // extra send pulses at cycles 5 and 30 of the frame.
    task automatic run_frame(input logic [DW-1:0] d, input bit chg, input bit extra);
        data   = d;
        send_n = 1'b0;
        tick();
        send_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            chk("frame_serial", 32'(serial), 32'(exp_bit(d, i / BP)));
            chk("frame_busy", 32'(busy), 32'd1);
            chk("frame_done", 32'(done_n), 32'd1);
            if (chg && i == 10) data = 8'hFF;
            if (extra && (i == 5 || i == 30)) send_n = 1'b0;
            tick();
            send_n = 1'b1;
        end
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done_n), 32'd0);
        chk("end_serial", 32'(serial), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_idle("post");
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        data     = '0;
        send_n   = 1'b1;

        // 1. reset, then a mid-clock re-assertion, then 20 quiet cycles
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("rst_init");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle("rst_mid");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("quiet");
        end

        // 2. single frame 0xA5
        run_frame(8'hA5, 1'b0, 1'b0);

        // 3. data change during frame
        run_frame(8'hA5, 1'b1, 1'b0);

        // 4. held request, three back-to-back frames of 0x3C
        data   = 8'h3C;
        send_n = 1'b0;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                chk("held_serial", 32'(serial), 32'(exp_bit(8'h3C, i / BP)));
                chk("held_busy", 32'(busy), 32'd1);
                chk("held_done", 32'(done_n), 32'd1);
                tick();
            end
            chk("gap_serial", 32'(serial), 32'd1);
            chk("gap_busy", 32'(busy), 32'd0);
            chk("gap_done", 32'(done_n), 32'd0);
            if (f == 2) send_n = 1'b1;
            tick();
        end
        check_idle("held_end");
        tick();
        check_idle("held_end2");

        // 5. send pulses while busy are ignored
        run_frame(8'h96, 1'b0, 1'b1);

        // 6. reset during data bit 3 aborts the frame
        data   = 8'hA5;
        send_n = 1'b0;
        tick();
        send_n = 1'b1;
        for (int i = 0; i < 4 * BP + 1; i++) begin
            chk("pre_abort_serial", 32'(serial), 32'(exp_bit(8'hA5, i / BP)));
            tick();
        end
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1 check_idle("abort");
        @(posedge clk);
        #2 check_idle("abort_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_idle("after_abort");
        end

        // recovery with a fresh request
        run_frame(8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
